// File: rtl/dmi_jtag_dtm_pkg.sv
// Shared DTM types: DMI request/response, DTM op and response codes, IR opcodes, TAP states, DTMCS layout.
// Optional IDCODE register controlled by DMI_JTAG_IDCODE_EN.
package dm;

   localparam int ABITS = 7;

   typedef enum logic [1:0] {
      DTM_NOP   = 2'd0,
      DTM_READ  = 2'd1,
      DTM_WRITE = 2'd2
   } dtm_op_e;

   localparam logic [1:0] DTM_SUCCESS = 2'd0;
   localparam logic [1:0] DTM_ERR     = 2'd2;
   localparam logic [1:0] DTM_BUSY    = 2'd3;

   typedef struct packed {
      logic [ABITS-1:0] addr;
      logic [1:0]       op;
      logic [31:0]      data;
   } dmi_req_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } dmi_resp_t;

   localparam logic [4:0] IR_IDCODE    = 5'h01;
   localparam logic [4:0] IR_DTMCS     = 5'h10;
   localparam logic [4:0] IR_DMIACCESS = 5'h11;
   localparam logic [4:0] IR_BYPASS    = 5'h1f;
`ifdef DMI_JTAG_IDCODE_EN
   localparam logic [4:0] IR_RESET     = IR_IDCODE;
`else
   localparam logic [4:0] IR_RESET     = IR_BYPASS;
`endif

   localparam int         DTMCS_DMIRESET_BIT  = 16;
   localparam int         DTMCS_HARDRESET_BIT = 17;
   localparam logic [2:0] DTMCS_IDLE          = 3'd1;
   localparam logic [3:0] DTMCS_VERSION       = 4'd1;

   typedef enum logic [3:0] {
      TLR, RTI,
      SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
      SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
   } tap_state_e;

   typedef enum logic [1:0] {
      DMI_IDLE = 2'd0,
      DMI_REQ  = 2'd1,
      DMI_WAIT = 2'd2
   } dmi_state_e;

   function automatic logic [31:0] dtmcs_capture(input logic [1:0] dmistat);
      return {14'b0, 1'b0, 1'b0, 1'b0, DTMCS_IDLE, dmistat, 6'(ABITS), DTMCS_VERSION};
   endfunction

   function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
      case (s)
         TLR:      return tms ? TLR      : RTI;
         RTI:      return tms ? SEL_DR   : RTI;
         SEL_DR:   return tms ? SEL_IR   : CAP_DR;
         CAP_DR:   return tms ? EXIT1_DR : SHIFT_DR;
         SHIFT_DR: return tms ? EXIT1_DR : SHIFT_DR;
         EXIT1_DR: return tms ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: return tms ? EXIT2_DR : PAUSE_DR;
         EXIT2_DR: return tms ? UPD_DR   : SHIFT_DR;
         UPD_DR:   return tms ? SEL_DR   : RTI;
         SEL_IR:   return tms ? TLR      : CAP_IR;
         CAP_IR:   return tms ? EXIT1_IR : SHIFT_IR;
         SHIFT_IR: return tms ? EXIT1_IR : SHIFT_IR;
         EXIT1_IR: return tms ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: return tms ? EXIT2_IR : PAUSE_IR;
         EXIT2_IR: return tms ? UPD_IR   : SHIFT_IR;
         default:  return tms ? SEL_DR   : RTI;
      endcase
   endfunction

endpackage

// File: rtl/dmi_jtag_dtm_tap.sv
// JTAG TAP sampled in clk: pin synchronizers, TCK edge detect, TAP FSM, IR, BYPASS/IDCODE, TDO mux.
// IDCODE register present only when DMI_JTAG_IDCODE_EN is defined.
module dmi_jtag_tap
   import dm::*;
#(
   parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
   input  logic clk,
   input  logic rst,
   input  logic tck_i,
   input  logic tms_i,
   input  logic td_i,
   input  logic trst_ni,
   output logic td_o,
   output logic tdo_oe_o,
   output logic tap_clear,
   output logic capture_dr,
   output logic shift_dr,
   output logic update_dr,
   output logic dtmcs_sel,
   output logic dmi_sel,
   output logic tdi,
   input  logic dtmcs_tdo,
   input  logic dmi_tdo
);

   logic [1:0]  tck_sync, tms_sync, td_sync, trst_sync;
   logic        tck_q, trst_q;
   tap_state_e  state, state_nxt;
   logic [4:0]  ir, ir_sr;
   logic        bypass_sr;
   logic [31:0] idcode_sr;
   logic        idcode_sel, tck_rise, tck_fall, trst_act, rise_ok, dr_tdo;

   // TRST synchronizer idles high so reset release does not look like a TRST assertion
   always_ff @(posedge clk) begin
      if (rst) begin
         tck_sync  <= 2'b00;
         tms_sync  <= 2'b00;
         td_sync   <= 2'b00;
         trst_sync <= 2'b11;
         tck_q     <= 1'b0;
         trst_q    <= 1'b1;
      end else begin
         tck_sync  <= {tck_sync[0], tck_i};
         tms_sync  <= {tms_sync[0], tms_i};
         td_sync   <= {td_sync[0], td_i};
         trst_sync <= {trst_sync[0], trst_ni};
         tck_q     <= tck_sync[1];
         trst_q    <= trst_sync[1];
      end
   end

   assign tck_rise  = tck_sync[1] & ~tck_q;
   assign tck_fall  = ~tck_sync[1] & tck_q;
   assign trst_act  = ~trst_sync[1];
   assign rise_ok   = tck_rise & ~trst_act;
   assign tdi       = td_sync[1];
   assign state_nxt = tap_next(state, tms_sync[1]);

   assign tap_clear  = (trst_act & trst_q) |
                       (rise_ok & (state != TLR) & (state_nxt == TLR));
   assign capture_dr = rise_ok & (state == CAP_DR);
   assign shift_dr   = rise_ok & (state == SHIFT_DR);
   assign update_dr  = rise_ok & (state == UPD_DR);
   assign tdo_oe_o   = (state == SHIFT_DR) | (state == SHIFT_IR);

   assign dtmcs_sel  = (ir == IR_DTMCS);
   assign dmi_sel    = (ir == IR_DMIACCESS);
`ifdef DMI_JTAG_IDCODE_EN
   assign idcode_sel = (ir == IR_IDCODE);
`else
   assign idcode_sel = 1'b0;
`endif

   assign dr_tdo = dmi_sel    ? dmi_tdo :
                   dtmcs_sel  ? dtmcs_tdo :
                   idcode_sel ? idcode_sr[0] : bypass_sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= TLR;
         ir        <= IR_RESET;
         ir_sr     <= 5'd0;
         bypass_sr <= 1'b0;
         idcode_sr <= 32'd0;
         td_o      <= 1'b0;
      end else begin
         if (trst_act) begin
            state <= TLR;
            ir    <= IR_RESET;
         end else if (tck_rise) begin
            state <= state_nxt;
            if (state_nxt == TLR) ir <= IR_RESET;
            case (state)
               CAP_IR:   ir_sr <= 5'b00001;
               SHIFT_IR: ir_sr <= {tdi, ir_sr[4:1]};
               UPD_IR:   ir    <= ir_sr;
               CAP_DR: begin
                  bypass_sr <= 1'b0;
                  idcode_sr <= IDCODE_VAL | 32'h1;
               end
               SHIFT_DR: begin
                  bypass_sr <= tdi;
                  idcode_sr <= {tdi, idcode_sr[31:1]};
               end
               default: ;
            endcase
         end
         if (tck_fall) begin
            case (state)
               SHIFT_IR: td_o <= ir_sr[0];
               SHIFT_DR: td_o <= dr_tdo;
               default:  td_o <= 1'b0;
            endcase
         end
      end
   end

endmodule

// File: rtl/dmi_jtag_dtm.sv
// RISC-V JTAG DTM top: DTMCS and DMIACCESS registers, DMI request FSM and sticky error state.
// Build option DMI_JTAG_IDCODE_EN enables the IDCODE DR inside the TAP.
module dmi_jtag_dtm
   import dm::*;
#(
   parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      tck_i,
   input  logic      tms_i,
   input  logic      td_i,
   input  logic      trst_ni,
   output logic      td_o,
   output logic      tdo_oe_o,
   output logic      dbg_dmi_clear_o,
   output dmi_req_t  dbg_dmi_req_o,
   output logic      dbg_dmi_req_valid_o,
   input  logic      dbg_dmi_req_ready_i,
   input  dmi_resp_t dbg_dmi_resp_i,
   input  logic      dbg_dmi_resp_valid_i,
   output logic      dbg_dmi_resp_ready_o
);

   logic        tap_clear, capture_dr, shift_dr, update_dr, dtmcs_sel, dmi_sel, tdi;
   logic [31:0] dtmcs_sr;
   logic [40:0] dmi_sr;
   dmi_state_e  dmi_state;
   logic [1:0]  sticky, cap_status;
   logic [6:0]  last_addr;
   logic [31:0] last_rdata;
   logic        hardreset, dmireset, dmi_clear, busy, is_access;

   dmi_jtag_tap #(.IDCODE_VAL(IDCODE_VAL)) u_tap (
      .clk        (clk),
      .rst        (rst),
      .tck_i      (tck_i),
      .tms_i      (tms_i),
      .td_i       (td_i),
      .trst_ni    (trst_ni),
      .td_o       (td_o),
      .tdo_oe_o   (tdo_oe_o),
      .tap_clear  (tap_clear),
      .capture_dr (capture_dr),
      .shift_dr   (shift_dr),
      .update_dr  (update_dr),
      .dtmcs_sel  (dtmcs_sel),
      .dmi_sel    (dmi_sel),
      .tdi        (tdi),
      .dtmcs_tdo  (dtmcs_sr[0]),
      .dmi_tdo    (dmi_sr[0])
   );

   assign hardreset  = update_dr & dtmcs_sel & dtmcs_sr[DTMCS_HARDRESET_BIT];
   assign dmireset   = update_dr & dtmcs_sel & dtmcs_sr[DTMCS_DMIRESET_BIT];
   assign dmi_clear  = tap_clear | hardreset;
   assign busy       = (dmi_state != DMI_IDLE);
   assign is_access  = (dmi_sr[1:0] == DTM_READ) || (dmi_sr[1:0] == DTM_WRITE);
   assign cap_status = (sticky != DTM_SUCCESS) ? sticky :
                       busy                    ? DTM_BUSY : DTM_SUCCESS;

   assign dbg_dmi_req_valid_o  = (dmi_state == DMI_REQ);
   assign dbg_dmi_resp_ready_o = (dmi_state == DMI_WAIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         dtmcs_sr        <= 32'd0;
         dmi_sr          <= 41'd0;
         dmi_state       <= DMI_IDLE;
         sticky          <= DTM_SUCCESS;
         last_addr       <= 7'd0;
         last_rdata      <= 32'd0;
         dbg_dmi_req_o   <= '0;
         dbg_dmi_clear_o <= 1'b0;
      end else begin
         dbg_dmi_clear_o <= dmi_clear;

         if (dtmcs_sel && capture_dr)   dtmcs_sr <= dtmcs_capture(sticky);
         else if (dtmcs_sel && shift_dr) dtmcs_sr <= {tdi, dtmcs_sr[31:1]};

         if (dmi_sel && capture_dr)   dmi_sr <= {last_addr, last_rdata, cap_status};
         else if (dmi_sel && shift_dr) dmi_sr <= {tdi, dmi_sr[40:1]};

         // A clear aborts the transaction and takes priority over any Update-DR this cycle
         if (dmi_clear) begin
            dmi_state <= DMI_IDLE;
            sticky    <= DTM_SUCCESS;
         end else begin
            case (dmi_state)
               DMI_IDLE: ;
               DMI_REQ:  if (dbg_dmi_req_ready_i) dmi_state <= DMI_WAIT;
               DMI_WAIT: if (dbg_dmi_resp_valid_i) begin
                  last_rdata <= dbg_dmi_resp_i.data;
                  if (dbg_dmi_resp_i.resp != DTM_SUCCESS)
                     sticky <= (dbg_dmi_resp_i.resp == DTM_BUSY) ? DTM_BUSY : DTM_ERR;
                  dmi_state <= DMI_IDLE;
               end
               default:  dmi_state <= DMI_IDLE;
            endcase

            if (dmireset) sticky <= DTM_SUCCESS;

            // Reading status while busy makes the busy condition sticky
            if (dmi_sel && capture_dr && (sticky == DTM_SUCCESS) && busy)
               sticky <= DTM_BUSY;

            if (dmi_sel && update_dr && is_access) begin
               if (busy) begin
                  sticky <= DTM_BUSY;
               end else if (sticky == DTM_SUCCESS) begin
                  dbg_dmi_req_o <= '{addr: dmi_sr[40:34], op: dmi_sr[1:0], data: dmi_sr[33:2]};
                  last_addr     <= dmi_sr[40:34];
                  dmi_state     <= DMI_REQ;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_dmi_jtag_dtm.sv
// Directed bench for dmi_jtag_dtm: bit-banged JTAG scans with a hand-driven DMI responder.
module tb_dmi_jtag_dtm;
   import dm::*;

   localparam logic [31:0] IDCODE_VAL = 32'h1000_0001;

   logic      clk = 1'b0;
   logic      rst, tck, tms, tdi, trst_n;
   logic      tdo, tdo_oe, dmi_clear, req_valid, req_ready, resp_valid, resp_ready;
   dmi_req_t  req;
   dmi_resp_t resp;
   int        checks = 0;
   int        errors = 0;
   int        clr_cnt = 0;
   int        beats = 0;

   dmi_jtag_dtm #(.IDCODE_VAL(IDCODE_VAL)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .tck_i                (tck),
      .tms_i                (tms),
      .td_i                 (tdi),
      .trst_ni              (trst_n),
      .td_o                 (tdo),
      .tdo_oe_o             (tdo_oe),
      .dbg_dmi_clear_o      (dmi_clear),
      .dbg_dmi_req_o        (req),
      .dbg_dmi_req_valid_o  (req_valid),
      .dbg_dmi_req_ready_i  (req_ready),
      .dbg_dmi_resp_i       (resp),
      .dbg_dmi_resp_valid_i (resp_valid),
      .dbg_dmi_resp_ready_o (resp_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dmi_clear)             clr_cnt <= clr_cnt + 1;
      if (req_valid & req_ready) beats   <= beats + 1;
   end

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic jtag_clk(input logic tms_v, input logic tdi_v, output logic tdo_v);
      tck = 1'b0;
      tms = tms_v;
      tdi = tdi_v;
      repeat (6) @(posedge clk);
      #1 tdo_v = tdo;
      tck = 1'b1;
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic goto_rti();
      logic b;
      for (int i = 0; i < 5; i++) jtag_clk(1'b1, 1'b0, b);
      jtag_clk(1'b0, 1'b0, b);
   endtask

   task automatic scan_ir(input logic [4:0] ir, output logic [4:0] cap);
      logic b;
      jtag_clk(1'b1, 1'b0, b);
      jtag_clk(1'b1, 1'b0, b);
      jtag_clk(1'b0, 1'b0, b);
      jtag_clk(1'b0, 1'b0, b);
      for (int i = 0; i < 5; i++) begin
         jtag_clk(i == 4, ir[i], b);
         cap[i] = b;
      end
      jtag_clk(1'b1, 1'b0, b);
      jtag_clk(1'b0, 1'b0, b);
   endtask

   task automatic scan_dr(input logic [40:0] din, input int n, output logic [40:0] dout);
      logic b;
      dout = '0;
      jtag_clk(1'b1, 1'b0, b);
      jtag_clk(1'b0, 1'b0, b);
      jtag_clk(1'b0, 1'b0, b);
      check_val("oe_shift", tdo_oe, 1'b1);
      for (int i = 0; i < n; i++) begin
         jtag_clk(i == n - 1, din[i], b);
         dout[i] = b;
      end
      jtag_clk(1'b1, 1'b0, b);
      jtag_clk(1'b0, 1'b0, b);
      check_val("oe_idle", tdo_oe, 1'b0);
   endtask

   task automatic wait_req(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d);
      int n = 0;
      while (!req_valid && n < 50) begin
         @(posedge clk);
         #1 n++;
      end
      check_val("req_valid", req_valid, 1'b1);
      check_val("req_addr", req.addr, a);
      check_val("req_op", req.op, op);
      check_val("req_data", req.data, d);
   endtask

   task automatic dmi_serve(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d,
                            input logic [31:0] rd, input logic [1:0] rc);
      wait_req(a, op, d);
      req_ready = 1'b1;
      @(posedge clk);
      #1 req_ready = 1'b0;
      check_val("req_drop", req_valid, 1'b0);
      check_val("resp_ready", resp_ready, 1'b1);
      resp.data  = rd;
      resp.resp  = rc;
      resp_valid = 1'b1;
      @(posedge clk);
      #1 resp_valid = 1'b0;
      check_val("resp_done", resp_ready, 1'b0);
   endtask

   initial begin
      logic [40:0] d;
      logic [4:0]  c;
      int          c0;
      logic [31:0] exp_id;

      rst = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b0; trst_n = 1'b1;
      req_ready = 1'b0; resp_valid = 1'b0; resp = '0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      check_val("rst_tdo", tdo, 1'b0);
      check_val("rst_oe", tdo_oe, 1'b0);
      check_val("rst_clear", dmi_clear, 1'b0);
      check_val("rst_valid", req_valid, 1'b0);
      check_val("rst_rready", resp_ready, 1'b0);
      check_val("rst_req", req, 41'd0);

      // IDCODE (or BYPASS with td=0) after reset
      goto_rti();
      scan_dr(41'd0, 32, d);
`ifdef DMI_JTAG_IDCODE_EN
      exp_id = IDCODE_VAL | 32'h1;
`else
      exp_id = 32'h0;
`endif
      check_val("idcode", d[31:0], exp_id);

      // DMI write
      scan_ir(IR_DMIACCESS, c);
      check_val("ir_capture", c, 5'b00001);
      scan_dr(41'h0401FFFFF06, 41, d);
      check_val("dmi_cap0", d, 41'd0);
      dmi_serve(7'h10, 2'd2, 32'h07FFFFC1, 32'h0, 2'd0);
      check_val("beats_wr", beats, 1);

      // DMI read and read-data capture
      scan_dr(41'h04000000001, 41, d);
      dmi_serve(7'h10, 2'd1, 32'h0, 32'hCAFEBABE, 2'd0);
      scan_dr(41'd0, 41, d);
      check_val("dmi_rdata", d, {7'h10, 32'hCAFEBABE, 2'b00});
      check_val("beats_rd", beats, 2);

      // Busy: rescan while outstanding
      scan_dr(41'h04000000001, 41, d);
      check_val("cap_idle", d[1:0], 2'd0);
      scan_dr(41'h04000000001, 41, d);
      check_val("busy_status", d[1:0], 2'd3);
      check_val("busy_pending", req_valid, 1'b1);
      check_val("busy_beats", beats, 2);
      scan_ir(IR_DTMCS, c);
      scan_dr(41'd0, 32, d);
      check_val("dtmcs_busy", d[31:0], 32'h1C71);
      dmi_serve(7'h10, 2'd1, 32'h0, 32'h12345678, 2'd0);
      scan_ir(IR_DMIACCESS, c);
      scan_dr({7'h05, 32'h55, 2'd2}, 41, d);
      check_val("sticky_cap", d[1:0], 2'd3);
      repeat (20) @(posedge clk);
      #1;
      check_val("sticky_ignored", req_valid, 1'b0);
      check_val("sticky_beats", beats, 3);
      scan_ir(IR_DTMCS, c);
      scan_dr(41'h10000, 32, d);
      check_val("dtmcs_pre_rst", d[31:0], 32'h1C71);
      scan_dr(41'd0, 32, d);
      check_val("dtmcs_dmireset", d[31:0], 32'h1071);

      // Error response and hard reset
      scan_ir(IR_DMIACCESS, c);
      scan_dr(41'h04000000001, 41, d);
      check_val("dmi_cap_ok", d, {7'h10, 32'h12345678, 2'b00});
      dmi_serve(7'h10, 2'd1, 32'h0, 32'hDEAD0000, 2'd2);
      scan_ir(IR_DTMCS, c);
      c0 = clr_cnt;
      scan_dr(41'd0, 32, d);
      check_val("dtmcs_err", d[31:0], 32'h1871);
      scan_dr(41'h20000, 32, d);
      check_val("dtmcs_err2", d[31:0], 32'h1871);
      check_val("hardreset_pulse", clr_cnt - c0, 1);
      scan_dr(41'd0, 32, d);
      check_val("dtmcs_hard", d[31:0], 32'h1071);

      // TRST in the middle of a transaction
      scan_ir(IR_DMIACCESS, c);
      scan_dr({7'h22, 32'h0, 2'd1}, 41, d);
      wait_req(7'h22, 2'd1, 32'h0);
      req_ready = 1'b1;
      @(posedge clk);
      #1 req_ready = 1'b0;
      check_val("trst_wait", resp_ready, 1'b1);
      c0 = clr_cnt;
      trst_n = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check_val("trst_valid", req_valid, 1'b0);
      check_val("trst_rready", resp_ready, 1'b0);
      check_val("trst_pulse", clr_cnt - c0, 1);
      check_val("trst_oe", tdo_oe, 1'b0);
      trst_n = 1'b1;
      repeat (4) @(posedge clk);
      goto_rti();
      scan_dr(41'hA5, 32, d);
`ifdef DMI_JTAG_IDCODE_EN
      exp_id = IDCODE_VAL | 32'h1;
`else
      exp_id = 32'h14A;
`endif
      check_val("ir_after_trst", d[31:0], exp_id);
      check_val("trst_one_pulse", clr_cnt - c0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
